emg_package_assembler: RTL and testbench



---
 rtl/emg_pkg.sv | 15 +
 rtl/byte_gap_timer.sv | 31 +++
 rtl/emg_package_assembler.sv | 157 +++++++++++++++
 tb/tb_emg_package_assembler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emg_pkg.sv
// Shared EMG package-stream definitions for the assembler and the threshold cutter.
package emg_pkg;

    localparam int unsigned PACKAGE_NUM       = 4;
    localparam int unsigned PACKAGE_BIT_WIDTH = PACKAGE_NUM << 3;
    localparam logic [7:0]  HEADER_BYTE       = 8'hA5;
    localparam int unsigned ERR_CNT_W         = 16;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2
    } asm_state_e;

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap counter: flags a frame that has stalled for TIMEOUT_CYCLES cycles.
module byte_gap_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire_c
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    // A byte in the threshold cycle clears the counter, so it beats the timeout.
    assign o_expire_c = i_en && !i_clr && (r_cnt == CNT_LAST);

    // Count idle cycles while a frame is open; hold at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_en || i_clr || o_expire_c) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/emg_package_assembler.sv
// Frames the UART byte stream into checksummed EMG packages for the threshold cutter.
module emg_package_assembler
    import emg_pkg::*;
#(
    parameter int unsigned PACKAGE_NUM    = emg_pkg::PACKAGE_NUM,
    parameter logic [7:0]  HEADER_BYTE    = emg_pkg::HEADER_BYTE,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [7:0]               byte_i,
    input  logic                     byte_valid,
    output logic [PACKAGE_NUM*8-1:0] package_o,
    output logic                     package_wen,
    output logic                     frame_err,
    output logic                     timeout_err,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int unsigned      PKG_W    = PACKAGE_NUM * 8;
    localparam int unsigned      IDX_W    = (PACKAGE_NUM > 1) ? $clog2(PACKAGE_NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKAGE_NUM - 1);

    asm_state_e           r_state;
    asm_state_e           w_state_nxt;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic [7:0]           r_sum;
    logic [7:0]           w_sum_nxt;
    logic [PKG_W-1:0]     r_shadow;
    logic [PKG_W-1:0]     w_shadow_nxt;
    logic [PKG_W-1:0]     r_package;
    logic [PKG_W-1:0]     w_package_nxt;
    logic                 r_wen;
    logic                 w_wen_nxt;
    logic                 r_frame_err;
    logic                 w_frame_err_nxt;
    logic                 r_timeout_err;
    logic                 w_timeout_err_nxt;
    logic [ERR_CNT_W-1:0] r_err_cnt;
    logic [ERR_CNT_W-1:0] w_err_cnt_nxt;
    logic                 w_timer_en;
    logic                 w_expire_c;

    assign w_timer_en = (r_state != HUNT);

    byte_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_en      (w_timer_en),
        .i_clr     (byte_valid),
        .o_expire_c(w_expire_c)
    );

    // Next-state, shadow fill, checksum compare and error pulses.
    always_comb begin
        w_state_nxt       = r_state;
        w_idx_nxt         = r_idx;
        w_sum_nxt         = r_sum;
        w_shadow_nxt      = r_shadow;
        w_package_nxt     = r_package;
        w_wen_nxt         = 1'b0;
        w_frame_err_nxt   = 1'b0;
        w_timeout_err_nxt = 1'b0;

        unique case (r_state)
            HUNT: begin
                if (byte_valid && (byte_i == HEADER_BYTE)) begin
                    w_state_nxt = PAYLOAD;
                    w_idx_nxt   = '0;
                    w_sum_nxt   = '0;
                end
            end
            PAYLOAD: begin
                // A header value here is ordinary payload; there is no resync.
                if (byte_valid) begin
                    for (int unsigned k = 0; k < PACKAGE_NUM; k++) begin
                        if (r_idx == IDX_W'(k)) begin
                            w_shadow_nxt[k*8 +: 8] = byte_i;
                        end
                    end
                    w_sum_nxt = r_sum + byte_i;
                    w_idx_nxt = IDX_W'(r_idx + 1'b1);
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = CHECK;
                    end
                end else if (w_expire_c) begin
                    w_state_nxt       = HUNT;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            CHECK: begin
                if (byte_valid) begin
                    w_state_nxt = HUNT;
                    if (byte_i == r_sum) begin
                        w_package_nxt = r_shadow;
                        w_wen_nxt     = 1'b1;
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end else if (w_expire_c) begin
                    w_state_nxt       = HUNT;
                    w_timeout_err_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase

        w_err_cnt_nxt = r_err_cnt;
        if ((w_frame_err_nxt || w_timeout_err_nxt) && (r_err_cnt != '1)) begin
            w_err_cnt_nxt = r_err_cnt + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_sum         <= '0;
            r_shadow      <= '0;
            r_package     <= '0;
            r_wen         <= 1'b0;
            r_frame_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_err_cnt     <= '0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_sum         <= w_sum_nxt;
            r_shadow      <= w_shadow_nxt;
            r_package     <= w_package_nxt;
            r_wen         <= w_wen_nxt;
            r_frame_err   <= w_frame_err_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_err_cnt     <= w_err_cnt_nxt;
        end
    end

    assign package_o   = r_package;
    assign package_wen = r_wen;
    assign frame_err   = r_frame_err;
    assign timeout_err = r_timeout_err;
    assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_emg_package_assembler.sv
// Self-checking bench for emg_package_assembler (PACKAGE_NUM=4, TIMEOUT_CYCLES=8).
module tb_emg_package_assembler;

    localparam int unsigned N   = 4;
    localparam int unsigned TO  = 8;
    localparam logic [7:0]  HDR = 8'hA5;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [7:0]      byte_i = 8'h00;
    logic            byte_valid = 1'b0;
    logic [N*8-1:0]  package_o;
    logic            package_wen;
    logic            frame_err;
    logic            timeout_err;
    logic [15:0]     err_cnt;

    emg_package_assembler #(
        .PACKAGE_NUM   (N),
        .HEADER_BYTE   (HDR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_i     (byte_i),
        .byte_valid (byte_valid),
        .package_o  (package_o),
        .package_wen(package_wen),
        .frame_err  (frame_err),
        .timeout_err(timeout_err),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: last good package and saturating error count.
    logic [31:0] m_pkg = 32'h0;
    int          m_err = 0;

    // Event log captured at each falling edge.
    int          wen_cyc_q[$];
    logic [31:0] wen_pkg_q[$];
    int          ferr_cyc_q[$];
    int          terr_cyc_q[$];
    int          partial_cnt = 0;
    logic [31:0] prev_pkg = 32'h0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (package_wen) begin
                wen_cyc_q.push_back(cyc);
                wen_pkg_q.push_back(package_o);
            end
            if (frame_err)   ferr_cyc_q.push_back(cyc);
            if (timeout_err) terr_cyc_q.push_back(cyc);
            if (!package_wen && (package_o !== prev_pkg)) partial_cnt++;
        end
        prev_pkg = package_o;
    end

    function automatic int obs(input int q[$]);
        if (q.size() == 0) return -1;
        if (q.size() > 1)  return -2;
        return q[0];
    endfunction

    function automatic logic [7:0] csum(input logic [31:0] p);
        int s = 0;
        for (int k = 0; k < 4; k++) s += int'(p[8*k +: 8]);
        return 8'(s % 256);
    endfunction

    function automatic logic [31:0] first_pkg();
        return (wen_pkg_q.size() == 1) ? wen_pkg_q[0] : 32'hxxxxxxxx;
    endfunction

    function automatic void bump_err();
        m_err = (m_err < 65535) ? m_err + 1 : 65535;
    endfunction

    task automatic clear_q();
        wen_cyc_q.delete();
        wen_pkg_q.delete();
        ferr_cyc_q.delete();
        terr_cyc_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            byte_valid = 1'b0;
            byte_i     = 8'($urandom);
        end
    endtask

    // Drive one byte after `gap` idle cycles; e is the edge that captures it.
    task automatic send(input logic [7:0] b, input int gap, output int e);
        idle(gap);
        @(negedge clk);
        byte_i     = b;
        byte_valid = 1'b1;
        e          = cyc + 1;
    endtask

    task automatic send_frame(input logic [31:0] p, input logic [7:0] chk,
                              input int maxgap, output int chk_edge);
        int e;
        send(HDR, 0, e);
        for (int k = 0; k < 4; k++) send(p[8*k +: 8], $urandom_range(maxgap, 0), e);
        send(chk, $urandom_range(maxgap, 0), chk_edge);
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        #1;
        n_vec++; if (package_o !== 32'h0) begin n_err++; $display("FAIL reset_package got %h exp 0", package_o); end
        n_vec++; if (package_wen !== 1'b0) begin n_err++; $display("FAIL reset_wen got %b exp 0", package_wen); end
        n_vec++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
        n_vec++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL reset_timeout_err got %b exp 0", timeout_err); end
        n_vec++; if (err_cnt !== 16'h0) begin n_err++; $display("FAIL reset_err_cnt got %h exp 0", err_cnt); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(3); #1;
        n_vec++; if ((package_wen | frame_err | timeout_err) !== 1'b0) begin n_err++; $display("FAIL idle_after_reset got %b%b%b exp 000", package_wen, frame_err, timeout_err); end
        clear_q();
    endtask

    task automatic test_good_frame();
        int ce;
        send_frame(32'h44332211, 8'hAA, 0, ce);
        idle(3); #1;
        m_pkg = 32'h44332211;
        n_vec++; if (obs(wen_cyc_q) !== ce) begin n_err++; $display("FAIL good_wen_cycle got %0d exp %0d", obs(wen_cyc_q), ce); end
        n_vec++; if (first_pkg() !== m_pkg) begin n_err++; $display("FAIL good_wen_package got %h exp %h", first_pkg(), m_pkg); end
        n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL good_package_hold got %h exp %h", package_o, m_pkg); end
        n_vec++; if (err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL good_err_cnt got %0d exp %0d", err_cnt, m_err); end
        n_vec++; if (obs(ferr_cyc_q) !== -1) begin n_err++; $display("FAIL good_no_frame_err got %0d exp -1", obs(ferr_cyc_q)); end
        clear_q();
    endtask

    task automatic test_bad_checksum();
        int ce;
        send_frame(32'h04030201, 8'h0B, 0, ce);
        idle(3); #1;
        bump_err();
        n_vec++; if (obs(ferr_cyc_q) !== ce) begin n_err++; $display("FAIL bad_frame_err_cycle got %0d exp %0d", obs(ferr_cyc_q), ce); end
        n_vec++; if (obs(wen_cyc_q) !== -1) begin n_err++; $display("FAIL bad_no_wen got %0d exp -1", obs(wen_cyc_q)); end
        n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL bad_package_kept got %h exp %h", package_o, m_pkg); end
        n_vec++; if (err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL bad_err_cnt got %0d exp %0d", err_cnt, m_err); end
        clear_q();
        send_frame(32'h04030201, 8'h0A, 0, ce);
        idle(3); #1;
        m_pkg = 32'h04030201;
        n_vec++; if (obs(wen_cyc_q) !== ce) begin n_err++; $display("FAIL fixed_wen_cycle got %0d exp %0d", obs(wen_cyc_q), ce); end
        n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL fixed_package got %h exp %h", package_o, m_pkg); end
        clear_q();
    endtask

    task automatic test_header_in_payload();
        int e, ce;
        send(8'h00, 0, e);
        send(8'hFF, 0, e);
        send_frame(32'hA5A5A5A5, 8'h94, 0, ce);
        idle(3); #1;
        m_pkg = 32'hA5A5A5A5;
        n_vec++; if (obs(wen_cyc_q) !== ce) begin n_err++; $display("FAIL hdr_wen_cycle got %0d exp %0d", obs(wen_cyc_q), ce); end
        n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL hdr_package got %h exp %h", package_o, m_pkg); end
        n_vec++; if (err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL hdr_err_cnt got %0d exp %0d", err_cnt, m_err); end
        clear_q();
    endtask

    task automatic test_timeout();
        int e, le, ce;
        send(HDR, 0, e);
        send(8'h01, 0, le);
        idle(TO + 2); #1;
        bump_err();
        n_vec++; if (obs(terr_cyc_q) !== le + int'(TO)) begin n_err++; $display("FAIL timeout_cycle got %0d exp %0d", obs(terr_cyc_q), le + int'(TO)); end
        n_vec++; if (err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL timeout_err_cnt got %0d exp %0d", err_cnt, m_err); end
        n_vec++; if ((obs(wen_cyc_q) !== -1) || (obs(ferr_cyc_q) !== -1)) begin n_err++; $display("FAIL timeout_side_events got wen %0d ferr %0d exp -1", obs(wen_cyc_q), obs(ferr_cyc_q)); end
        clear_q();
        // Bytes arriving exactly at the threshold cycle keep the frame alive.
        send(HDR, 0, e);
        send(8'h10, 0, e);
        send(8'h20, TO - 1, e);
        send(8'h30, 0, e);
        send(8'h40, TO - 1, e);
        send(8'hA0, TO - 1, ce);
        idle(3); #1;
        m_pkg = 32'h40302010;
        n_vec++; if (obs(terr_cyc_q) !== -1) begin n_err++; $display("FAIL threshold_no_timeout got %0d exp -1", obs(terr_cyc_q)); end
        n_vec++; if (obs(wen_cyc_q) !== ce) begin n_err++; $display("FAIL threshold_wen_cycle got %0d exp %0d", obs(wen_cyc_q), ce); end
        n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL threshold_package got %h exp %h", package_o, m_pkg); end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int ce1, ce2;
        logic [31:0] pa, pb;
        pa = $urandom;
        pb = $urandom;
        send_frame(pa, csum(pa), 0, ce1);
        send_frame(pb, csum(pb), 0, ce2);
        idle(3); #1;
        m_pkg = pb;
        n_vec++; if ((wen_cyc_q.size() != 2) || (wen_cyc_q[0] != ce1) || (wen_cyc_q[1] != ce2)) begin n_err++; $display("FAIL b2b_wen_cycles got %0d pulses exp %0d,%0d", wen_cyc_q.size(), ce1, ce2); end
        n_vec++; if ((wen_pkg_q.size() != 2) || (wen_pkg_q[0] !== pa) || (wen_pkg_q[1] !== pb)) begin n_err++; $display("FAIL b2b_packages got %0d entries exp %h,%h", wen_pkg_q.size(), pa, pb); end
        n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL b2b_package_hold got %h exp %h", package_o, m_pkg); end
        clear_q();
    endtask

    task automatic test_random();
        int e, ce, le, kind, nb, exp_wen, exp_ferr, exp_terr;
        logic [31:0] p;
        logic [7:0]  b, chk;
        for (int f = 0; f < 40; f++) begin
            for (int j = $urandom_range(3, 0); j > 0; j--) begin
                do b = 8'($urandom); while (b == HDR);
                send(b, $urandom_range(7, 0), e);
            end
            p = $urandom;
            kind = $urandom_range(3, 0);
            exp_wen = -1; exp_ferr = -1; exp_terr = -1;
            if (kind == 3) begin
                nb = $urandom_range(N, 0);
                send(HDR, 0, le);
                for (int k = 0; k < nb; k++) send(p[8*k +: 8], $urandom_range(7, 0), le);
                idle(TO + $urandom_range(3, 0));
                exp_terr = le + int'(TO);
                bump_err();
            end else begin
                chk = (kind == 2) ? (csum(p) ^ 8'($urandom_range(255, 1))) : csum(p);
                send_frame(p, chk, 7, ce);
                if (kind == 2) begin exp_ferr = ce; bump_err(); end
                else begin exp_wen = ce; m_pkg = p; end
            end
            idle(3); #1;
            n_vec++; if (obs(wen_cyc_q) !== exp_wen) begin n_err++; $display("FAIL rand%0d_wen got %0d exp %0d", f, obs(wen_cyc_q), exp_wen); end
            n_vec++; if (obs(ferr_cyc_q) !== exp_ferr) begin n_err++; $display("FAIL rand%0d_frame_err got %0d exp %0d", f, obs(ferr_cyc_q), exp_ferr); end
            n_vec++; if (obs(terr_cyc_q) !== exp_terr) begin n_err++; $display("FAIL rand%0d_timeout got %0d exp %0d", f, obs(terr_cyc_q), exp_terr); end
            n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL rand%0d_package got %h exp %h", f, package_o, m_pkg); end
            n_vec++; if (err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL rand%0d_err_cnt got %0d exp %0d", f, err_cnt, m_err); end
            clear_q();
        end
    endtask

    task automatic test_err_saturation();
        int ce;
        @(negedge clk);
        force dut.r_err_cnt = 16'hFFFE;
        #1 release dut.r_err_cnt;
        m_err = 65534;
        send_frame(32'h01020304, 8'h00, 0, ce);
        idle(3); #1;
        bump_err();
        n_vec++; if (err_cnt !== 16'hFFFF) begin n_err++; $display("FAIL sat_reach got %h exp FFFF", err_cnt); end
        send_frame(32'h01020304, 8'h00, 0, ce);
        idle(3); #1;
        bump_err();
        n_vec++; if (err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL sat_hold got %h exp %h", err_cnt, 16'(m_err)); end
        clear_q();
    endtask

    task automatic test_reset_mid_frame();
        int e, ce;
        logic [31:0] p;
        send(HDR, 0, e);
        send(8'h11, 0, e);
        send(8'h22, 0, e);
        @(negedge clk);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (package_o !== 32'h0) begin n_err++; $display("FAIL midrst_package got %h exp 0", package_o); end
        n_vec++; if (err_cnt !== 16'h0) begin n_err++; $display("FAIL midrst_err_cnt got %h exp 0", err_cnt); end
        n_vec++; if ((package_wen | frame_err | timeout_err) !== 1'b0) begin n_err++; $display("FAIL midrst_pulses got %b%b%b exp 000", package_wen, frame_err, timeout_err); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_pkg = 32'h0;
        m_err = 0;
        clear_q();
        send(8'h33, 0, e);
        send(8'h44, 0, e);
        send(8'hAA, 0, e);
        idle(TO + 3); #1;
        n_vec++; if ((obs(wen_cyc_q) !== -1) || (obs(terr_cyc_q) !== -1) || (obs(ferr_cyc_q) !== -1)) begin n_err++; $display("FAIL midrst_abort got wen %0d terr %0d ferr %0d exp -1", obs(wen_cyc_q), obs(terr_cyc_q), obs(ferr_cyc_q)); end
        p = $urandom;
        send_frame(p, csum(p), 3, ce);
        idle(3); #1;
        m_pkg = p;
        n_vec++; if (obs(wen_cyc_q) !== ce) begin n_err++; $display("FAIL postrst_wen got %0d exp %0d", obs(wen_cyc_q), ce); end
        n_vec++; if (package_o !== m_pkg) begin n_err++; $display("FAIL postrst_package got %h exp %h", package_o, m_pkg); end
        n_vec++; if (err_cnt !== 16'(m_err)) begin n_err++; $display("FAIL postrst_err_cnt got %0d exp %0d", err_cnt, m_err); end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_header_in_payload();
        test_timeout();
        test_back_to_back();
        test_random();
        test_err_saturation();
        test_reset_mid_frame();
        n_vec++; if (partial_cnt !== 0) begin n_err++; $display("FAIL package_changed_without_wen got %0d exp 0", partial_cnt); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got time %0t exp completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
